reg_select_sequencer: RTL and testbench
=======================================

Name: reg_select_sequencer

Overview:
Upstream feeder for the 4-to-16 register-select decoder. It holds the instruction register (IR) and, on command, steps through the Rb, Rc and Ra fields of the latched instruction, presenting one 4-bit register index per phase. The decoder turns each index into a one-hot register enable. A valid/ready handshake paces the phases against the datapath's register-transfer timing. The block also produces the sign-extended C immediate from the IR.

Parameters:
IR_WIDTH, 32, instruction register width
RA_LSB, 23, LSB of 4-bit Ra field (Ra = IR[26:23])
RB_LSB, 19, LSB of 4-bit Rb field (Rb = IR[22:19])
RC_LSB, 15, LSB of 4-bit Rc field (Rc = IR[18:15]); C immediate = IR[RC_LSB+3:0]
TIMEOUT, 15, handshake watchdog limit in cycles (used only with SEL_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
clear  in  1  asynchronous active-high reset
ir_load  in  1  capture ir_in into IR (honoured only in IDLE)
ir_in  in  IR_WIDTH  instruction word from bus
start  in  1  begin a select sequence (honoured only in IDLE)
ops  in  3  {wr_a, rd_c, rd_b} phase enables, sampled with start
sel_out  out  4  register index to decoder
sel_valid  out  1  sel_out valid
sel_ready  in  1  datapath has consumed current index
sel_phase  out  2  0=Ra, 1=Rb, 2=Rc, 3=none
rd_en  out  1  sel_valid during Rb/Rc phase
wr_en  out  1  sel_valid during Ra phase
busy  out  1  high in RD_B/RD_C/WR_A
done  out  1  one-cycle completion pulse
err  out  1  one-cycle timeout pulse (0 without SEL_TIMEOUT_EN)
ir_q  out  IR_WIDTH  latched IR
c_sext  out  32  IR[RC_LSB+3:0] sign-extended from its MSB

Behaviour:
- Reset (clear high, async): state=IDLE; ir_q=0; sel_out=0; sel_phase=3; sel_valid, rd_en, wr_en, busy, done, err = 0; ops register=0.
- States: IDLE, RD_B, RD_C, WR_A, DONE. Phase order is fixed: Rb, then Rc, then Ra. Phases whose ops bit is 0 are skipped.
- IDLE, start=1: latch ops and go to the first enabled phase. If ops=0, go to DONE. sel_valid rises in the cycle after start (latency 1).
- Same-edge ir_load and start in IDLE: IR updates on that edge, and the sequence uses the new IR.
- In IDLE, start=0, ir_load=1: IR captures ir_in.
- ir_load and start are ignored in all states other than IDLE. IR is frozen for the whole sequence.
- Each phase: sel_out = the corresponding IR field, registered. sel_valid, sel_out and sel_phase stay stable until sel_valid & sel_ready is sampled at a rising edge.
- On handshake: move to the next enabled phase, or to DONE. There is no bubble: sel_valid stays high across back-to-back phases and sel_out changes on the handshake edge.
- DONE: done=1 for exactly one cycle, sel_valid=0, sel_phase=3, then IDLE. start during DONE is ignored.
- rd_en = sel_valid & (phase Rb or Rc); wr_en = sel_valid & phase Ra. Both are registered together with sel_valid.
- c_sext is combinational from ir_q: bits [18:0] = ir_q[18:0], bits [31:19] = ir_q[18].
- clear asserted mid-sequence: immediate return to reset values with no done pulse. Any in-flight handshake is dropped.

Optional Feature:
SEL_TIMEOUT_EN
- Defined: a 4-bit wait counter clears on every phase entry and on every handshake, and increments each cycle that sel_valid & !sel_ready.
  - When the counter reaches TIMEOUT, the FSM returns to IDLE on the next edge. err pulses for one cycle and done is not asserted.
- Not defined: no counter; err is tied to 0 and the FSM waits indefinitely for sel_ready.

Test Plan:
- Reset: assert clear mid-cycle with ops=3'b111 → all outputs go to reset values asynchronously, ir_q=0x00000000, sel_phase=3.
- Full sequence: ir_load with 0x192B8000, then start with ops=3'b111 and sel_ready=1 → sel_out 5 (rd_en), then 7 (rd_en), then 2 (wr_en) on consecutive cycles; done pulses on the next cycle; busy is high for exactly 3 cycles.
- Backpressure and skip: same IR, ops=3'b101, sel_ready held low for 4 cycles in the Rb phase → sel_out=5 holds for 5 cycles, then sel_out=2 with wr_en=1; the Rc phase never appears.
- ops=0, plus ignored inputs:
  - start with ops=0 → done pulses in the next cycle; sel_valid never rises.
  - ir_load=1 and start=1 while busy → both are ignored and ir_q is unchanged.
- Sign extension: IR=0x0007FFFF → c_sext=0xFFFFFFFF; IR=0x00040000 → 0xFFFC0000; IR=0x192B8000 → 0x00038000.
- SEL_TIMEOUT_EN defined: start with ops=3'b010 and sel_ready=0 → err pulses after 15 stalled cycles, the FSM returns to IDLE, and done stays 0.

Source files
------------

// File: rtl/reg_select_sequencer.sv
// reg_select_sequencer
// Holds the instruction register and walks the Rb, Rc and Ra fields of the
// latched instruction, presenting one 4-bit register index per phase to the
// 4-to-16 register-select decoder under a valid/ready handshake. Also
// produces the sign-extended C immediate from the IR.
//
// Optional feature macro: SEL_TIMEOUT_EN
//   defined   : a handshake watchdog aborts a stalled phase after TIMEOUT
//               cycles and pulses o_err
//   undefined : no watchdog, o_err tied low, phases wait indefinitely
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; IR may be loaded
// RD_B  | presenting Rb index (read), phase 1
// RD_C  | presenting Rc index (read), phase 2
// WR_A  | presenting Ra index (write), phase 0
// DONE  | one-cycle completion pulse, then back to IDLE

module reg_select_sequencer #(
    parameter int IR_WIDTH = 32,
    parameter int RA_LSB   = 23,
    parameter int RB_LSB   = 19,
    parameter int RC_LSB   = 15,
    parameter int TIMEOUT  = 15
) (
    input  logic                i_clk,
    input  logic                i_clear,
    input  logic                i_ir_load,
    input  logic [IR_WIDTH-1:0] i_ir_in,
    input  logic                i_start,
    input  logic [2:0]          i_ops,
    output logic [3:0]          o_sel_out,
    output logic                o_sel_valid,
    input  logic                i_sel_ready,
    output logic [1:0]          o_sel_phase,
    output logic                o_rd_en,
    output logic                o_wr_en,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic [IR_WIDTH-1:0] o_ir_q,
    output logic [31:0]         o_c_sext
);

    // Width of the C immediate field, MSB is its sign bit.
    localparam int CW = RC_LSB + 4;

    localparam logic [1:0] PH_RA   = 2'd0;
    localparam logic [1:0] PH_RB   = 2'd1;
    localparam logic [1:0] PH_RC   = 2'd2;
    localparam logic [1:0] PH_NONE = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_B = 3'd1,
        S_RD_C = 3'd2,
        S_WR_A = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IR_WIDTH-1:0]   r_ir;
    logic [IR_WIDTH-1:0]   w_ir_nxt;
    logic [2:0]            r_ops;
    logic [3:0]            r_sel_out;
    logic [1:0]            r_sel_phase;
    logic                  r_sel_valid;
    logic                  r_rd_en;
    logic                  r_wr_en;
    logic                  r_done;
    logic [3:0]            w_sel_out_nxt;
    logic [1:0]            w_sel_phase_nxt;
    logic                  w_sel_valid_nxt;
    logic                  w_rd_en_nxt;
    logic                  w_wr_en_nxt;
    logic                  w_in_phase;
    logic                  w_hs;
    logic                  w_timeout;

    assign w_in_phase = (r_state == S_RD_B) || (r_state == S_RD_C) || (r_state == S_WR_A);
    assign w_hs       = r_sel_valid & i_sel_ready;

    // The IR value the next cycle will see; lets a same-edge load+start
    // drive the first index from the freshly loaded word.
    assign w_ir_nxt = ((r_state == S_IDLE) && i_ir_load) ? i_ir_in : r_ir;

`ifdef SEL_TIMEOUT_EN
    logic [3:0] r_wait_cnt;
    logic       r_err;

    assign w_timeout = w_in_phase && (r_wait_cnt == 4'(TIMEOUT));

    // Watchdog: restart on phase entry or handshake, count stalled cycles.
    always_ff @(posedge i_clk or posedge i_clear) begin
        if (i_clear) begin
            r_wait_cnt <= 4'd0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if ((w_state_nxt != r_state) || w_hs) begin
                r_wait_cnt <= 4'd0;
            end else if (r_sel_valid && !i_sel_ready) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
        end
    end

    assign o_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign o_err     = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or posedge i_clear) begin
        if (i_clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: fixed Rb -> Rc -> Ra order, disabled phases skipped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_ops[0])      w_state_nxt = S_RD_B;
                    else if (i_ops[1]) w_state_nxt = S_RD_C;
                    else if (i_ops[2]) w_state_nxt = S_WR_A;
                    else               w_state_nxt = S_DONE;
                end
            end
            S_RD_B: begin
                if (w_hs) begin
                    if (r_ops[1])      w_state_nxt = S_RD_C;
                    else if (r_ops[2]) w_state_nxt = S_WR_A;
                    else               w_state_nxt = S_DONE;
                end
            end
            S_RD_C: begin
                if (w_hs) begin
                    if (r_ops[2]) w_state_nxt = S_WR_A;
                    else          w_state_nxt = S_DONE;
                end
            end
            S_WR_A: begin
                if (w_hs) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_timeout) w_state_nxt = S_IDLE;
    end

    // Output decode of the upcoming state; registered below so index,
    // phase and enables all change together on the same edge.
    always_comb begin
        w_sel_out_nxt   = 4'd0;
        w_sel_phase_nxt = PH_NONE;
        w_sel_valid_nxt = 1'b0;
        w_rd_en_nxt     = 1'b0;
        w_wr_en_nxt     = 1'b0;
        case (w_state_nxt)
            S_RD_B: begin
                w_sel_out_nxt   = w_ir_nxt[RB_LSB +: 4];
                w_sel_phase_nxt = PH_RB;
                w_sel_valid_nxt = 1'b1;
                w_rd_en_nxt     = 1'b1;
            end
            S_RD_C: begin
                w_sel_out_nxt   = w_ir_nxt[RC_LSB +: 4];
                w_sel_phase_nxt = PH_RC;
                w_sel_valid_nxt = 1'b1;
                w_rd_en_nxt     = 1'b1;
            end
            S_WR_A: begin
                w_sel_out_nxt   = w_ir_nxt[RA_LSB +: 4];
                w_sel_phase_nxt = PH_RA;
                w_sel_valid_nxt = 1'b1;
                w_wr_en_nxt     = 1'b1;
            end
            default: ;
        endcase
    end

    // Output, IR and ops registers.
    always_ff @(posedge i_clk or posedge i_clear) begin
        if (i_clear) begin
            r_ir        <= '0;
            r_ops       <= 3'd0;
            r_sel_out   <= 4'd0;
            r_sel_phase <= PH_NONE;
            r_sel_valid <= 1'b0;
            r_rd_en     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_ir        <= w_ir_nxt;
            if ((r_state == S_IDLE) && i_start) begin
                r_ops <= i_ops;
            end
            r_sel_out   <= w_sel_out_nxt;
            r_sel_phase <= w_sel_phase_nxt;
            r_sel_valid <= w_sel_valid_nxt;
            r_rd_en     <= w_rd_en_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    assign o_sel_out   = r_sel_out;
    assign o_sel_phase = r_sel_phase;
    assign o_sel_valid = r_sel_valid;
    assign o_rd_en     = r_rd_en;
    assign o_wr_en     = r_wr_en;
    assign o_done      = r_done;
    assign o_busy      = w_in_phase;
    assign o_ir_q      = r_ir;
    assign o_c_sext    = {{(32-CW){r_ir[CW-1]}}, r_ir[CW-1:0]};

endmodule

// File: tb/tb_reg_select_sequencer.sv
// Directed bench for reg_select_sequencer with hand-computed expectations.
// IR 0x192B8000 decodes to Rb=5, Rc=7, Ra=2, C immediate 0x38000.
// IR 0x01D60000 decodes to Rb=0xA, Rc=0xC, Ra=3.

module tb_reg_select_sequencer;

    logic        clk;
    logic        clear;
    logic        ir_load;
    logic [31:0] ir_in;
    logic        start;
    logic [2:0]  ops;
    logic [3:0]  sel_out;
    logic        sel_valid;
    logic        sel_ready;
    logic [1:0]  sel_phase;
    logic        rd_en;
    logic        wr_en;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] ir_q;
    logic [31:0] c_sext;

    int n_checks = 0;
    int n_errors = 0;

    reg_select_sequencer dut (
        .i_clk       (clk),
        .i_clear     (clear),
        .i_ir_load   (ir_load),
        .i_ir_in     (ir_in),
        .i_start     (start),
        .i_ops       (ops),
        .o_sel_out   (sel_out),
        .o_sel_valid (sel_valid),
        .i_sel_ready (sel_ready),
        .o_sel_phase (sel_phase),
        .o_rd_en     (rd_en),
        .o_wr_en     (wr_en),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .o_ir_q      (ir_q),
        .o_c_sext    (c_sext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Selector outputs as one word: {valid, rd_en, wr_en, busy, done, phase[1:0], sel[3:0]}
    function automatic logic [31:0] pack_sel();
        return {21'd0, sel_valid, rd_en, wr_en, busy, done, sel_phase, sel_out};
    endfunction

    function automatic logic [31:0] exp_sel(input logic v, input logic r, input logic w,
                                            input logic b, input logic d,
                                            input logic [1:0] ph, input logic [3:0] s);
        return {21'd0, v, r, w, b, d, ph, s};
    endfunction

    initial begin
        clear     = 1'b1;
        ir_load   = 1'b0;
        ir_in     = 32'd0;
        start     = 1'b0;
        ops       = 3'b000;
        sel_ready = 1'b0;

        // Reset state
        #12;
        chk("reset_sel", pack_sel(), exp_sel(0, 0, 0, 0, 0, 2'd3, 4'd0));
        chk("reset_ir", ir_q, 32'h0000_0000);
        chk("reset_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        clear = 1'b0;
        #4;

        // Load IR
        ir_load = 1'b1;
        ir_in   = 32'h192B_8000;
        step();
        ir_load = 1'b0;
        chk("load_ir", ir_q, 32'h192B_8000);
        chk("sext_pos", c_sext, 32'h0003_8000);

        // Full sequence, ready always high
        start     = 1'b1;
        ops       = 3'b111;
        sel_ready = 1'b1;
        step();
        start = 1'b0;
        chk("full_rb", pack_sel(), exp_sel(1, 1, 0, 1, 0, 2'd1, 4'd5));
        step();
        chk("full_rc", pack_sel(), exp_sel(1, 1, 0, 1, 0, 2'd2, 4'd7));
        step();
        chk("full_ra", pack_sel(), exp_sel(1, 0, 1, 1, 0, 2'd0, 4'd2));
        step();
        chk("full_done", pack_sel(), exp_sel(0, 0, 0, 0, 1, 2'd3, 4'd0));
        step();
        chk("full_idle", pack_sel(), exp_sel(0, 0, 0, 0, 0, 2'd3, 4'd0));

        // Backpressure with Rc skipped; busy-time load/start ignored
        start     = 1'b1;
        ops       = 3'b101;
        sel_ready = 1'b0;
        step();
        chk("bp_rb_c1", pack_sel(), exp_sel(1, 1, 0, 1, 0, 2'd1, 4'd5));
        ops     = 3'b010;
        ir_load = 1'b1;
        ir_in   = 32'hFFFF_FFFF;
        step();
        start   = 1'b0;
        ir_load = 1'b0;
        chk("bp_rb_c2", pack_sel(), exp_sel(1, 1, 0, 1, 0, 2'd1, 4'd5));
        chk("bp_ir_frozen", ir_q, 32'h192B_8000);
        step();
        chk("bp_rb_c3", pack_sel(), exp_sel(1, 1, 0, 1, 0, 2'd1, 4'd5));
        step();
        chk("bp_rb_c4", pack_sel(), exp_sel(1, 1, 0, 1, 0, 2'd1, 4'd5));
        step();
        chk("bp_rb_c5", pack_sel(), exp_sel(1, 1, 0, 1, 0, 2'd1, 4'd5));
        sel_ready = 1'b1;
        step();
        chk("bp_ra", pack_sel(), exp_sel(1, 0, 1, 1, 0, 2'd0, 4'd2));
        step();
        chk("bp_done", pack_sel(), exp_sel(0, 0, 0, 0, 1, 2'd3, 4'd0));
        start = 1'b1;
        ops   = 3'b111;
        step();
        start = 1'b0;
        chk("done_start_ignored", pack_sel(), exp_sel(0, 0, 0, 0, 0, 2'd3, 4'd0));

        // ops = 0: straight to DONE, no valid
        start = 1'b1;
        ops   = 3'b000;
        step();
        start = 1'b0;
        chk("ops0_done", pack_sel(), exp_sel(0, 0, 0, 0, 1, 2'd3, 4'd0));
        step();
        chk("ops0_idle", pack_sel(), exp_sel(0, 0, 0, 0, 0, 2'd3, 4'd0));

        // Sign extension corners
        ir_load = 1'b1;
        ir_in   = 32'h0007_FFFF;
        step();
        chk("sext_all1", c_sext, 32'hFFFF_FFFF);
        ir_in = 32'h0004_0000;
        step();
        ir_load = 1'b0;
        chk("sext_msb", c_sext, 32'hFFFC_0000);

        // Same-edge load and start uses the new IR
        ir_load = 1'b1;
        ir_in   = 32'h01D6_0000;
        start   = 1'b1;
        ops     = 3'b001;
        step();
        ir_load = 1'b0;
        start   = 1'b0;
        chk("same_edge_ir", ir_q, 32'h01D6_0000);
        chk("same_edge_rb", pack_sel(), exp_sel(1, 1, 0, 1, 0, 2'd1, 4'hA));
        step();
        chk("same_edge_done", pack_sel(), exp_sel(0, 0, 0, 0, 1, 2'd3, 4'd0));
        step();

        // Long stall in the Rc phase
        start     = 1'b1;
        ops       = 3'b010;
        sel_ready = 1'b0;
        step();
        start = 1'b0;
        chk("stall_rc_entry", pack_sel(), exp_sel(1, 1, 0, 1, 0, 2'd2, 4'hC));
`ifdef SEL_TIMEOUT_EN
        for (int i = 0; i < 15; i++) step();
        chk("to_before", {31'd0, err}, 32'd0);
        chk("to_still_rc", pack_sel(), exp_sel(1, 1, 0, 1, 0, 2'd2, 4'hC));
        step();
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_idle", pack_sel(), exp_sel(0, 0, 0, 0, 0, 2'd3, 4'd0));
        step();
        chk("to_err_pulse", {31'd0, err}, 32'd0);
        chk("to_no_done", pack_sel(), exp_sel(0, 0, 0, 0, 0, 2'd3, 4'd0));
`else
        for (int i = 0; i < 20; i++) step();
        chk("wait_still_rc", pack_sel(), exp_sel(1, 1, 0, 1, 0, 2'd2, 4'hC));
        chk("wait_no_err", {31'd0, err}, 32'd0);
        sel_ready = 1'b1;
        step();
        chk("wait_done", pack_sel(), exp_sel(0, 0, 0, 0, 1, 2'd3, 4'd0));
        step();
`endif

        // Asynchronous clear mid-sequence
        sel_ready = 1'b0;
        start     = 1'b1;
        ops       = 3'b111;
        step();
        start = 1'b0;
        chk("clr_pre", pack_sel(), exp_sel(1, 1, 0, 1, 0, 2'd1, 4'hA));
        #2;
        clear = 1'b1;
        #1;
        chk("clr_sel", pack_sel(), exp_sel(0, 0, 0, 0, 0, 2'd3, 4'd0));
        chk("clr_ir", ir_q, 32'h0000_0000);
        @(negedge clk);
        clear     = 1'b0;
        sel_ready = 1'b1;
        step();
        chk("clr_no_done", pack_sel(), exp_sel(0, 0, 0, 0, 0, 2'd3, 4'd0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
